alu_wb_p0: RTL
==============

ALU_WB_P0 -- requirements
Module: alu_wb_p0

Interface
REQ-001 Parameter: DEPTH, 8, result-queue entries (power of two, >= 8).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 instruction_i  input  INSTRUCTION_ALU  operands lhs[31:0], rhs[31:0], destination tag rd[6:0], alu_func; ALU_NOP = no instruction this cycle.
REQ-005 ready_o  output  1  high = scheduler may issue to port 0 this cycle.
REQ-006 wr_en  output  1  register-file write request for queue head.
REQ-007 wr_addr  output  7  physical destination tag of queue head.
REQ-008 wr_data  output  32  result of queue head.
REQ-009 wb_grant  input  1  shared write port granted to this unit this cycle.
REQ-010 wake_valid  output  1  completion broadcast, one cycle per retired result.
REQ-011 wake_tag  output  7  tag being broadcast.
REQ-012 overflow_o  output  1  sticky error: push attempted into full queue.

Function
REQ-013 Result computed combinationally from instruction_i, pushed into queue at next rising edge; 1-cycle input-to-wr_en latency when queue empty.
REQ-014 ADD: lhs+rhs mod 2^32; SUB: lhs-rhs mod 2^32.
REQ-015 SLL: lhs << rhs[4:0]; SR: logical right by rhs[4:0]; SRA: arithmetic right by rhs[4:0]; rhs[31:5] ignored.
REQ-016 SLT: 1 if signed lhs < signed rhs else 0; SLTU: same, unsigned; upper 31 bits zero.
REQ-017 XOR, OR, AND: bitwise 32-bit.
REQ-018 ALU_NOP or any unlisted encoding: no push, no other effect.
REQ-019 rd == 0: result discarded, no push, no wakeup.
REQ-020 Queue FIFO order, count 0..DEPTH, read/write pointers wrap modulo DEPTH.
REQ-021 wr_en = (count != 0); wr_addr/wr_data = head entry, stable while wr_en high and wb_grant low.
REQ-022 Pop when wr_en & wb_grant; wb_grant ignored when queue empty.
REQ-023 wake_valid = wr_en & wb_grant, wake_tag = wr_addr, same cycle as pop.
REQ-024 Simultaneous push and pop: both performed, count unchanged; legal when full (push accepted).
REQ-025 Push when full without pop: push dropped, queue unchanged, overflow_o set and held until reset.
REQ-026 ready_o = (count <= DEPTH-4), registered-state-only (no combinational path from instruction_i or wb_grant), covering up to 4 issues in flight upstream.
REQ-027 Empty-queue input does not bypass to wr_en in same cycle; write always from queue.

Reset
REQ-028 During reset: queue flushed (count 0, pointers 0), incoming instruction_i ignored.
REQ-029 Reset values: wr_en 0, wake_valid 0, ready_o 1, overflow_o 0; wr_addr/wr_data don't-care while wr_en 0.
REQ-030 Reset mid-operation: all queued, unwritten results discarded, no wakeup issued for them.

Verification
REQ-031 ADD lhs=0xFFFFFFFF rhs=1 rd=5, wb_grant=1 -> next cycle wr_en=1 wr_addr=5 wr_data=0, wake_valid=1 wake_tag=5, following cycle wr_en=0.
REQ-032 SRA lhs=0x80000000 rhs=0x21 -> 0xC0000000; SR same -> 0x40000000; SLT 0xFFFFFFFF vs 1 -> 1; SLTU same -> 0.
REQ-033 wb_grant=0, issue 5 ADDs rd=1..5 -> ready_o low once count reaches 5, wr_addr=1 held; then wb_grant=1 -> writes tags 1..5 in order, one per cycle, ready_o returns high.
REQ-034 Fill to DEPTH with wb_grant=0, push one more -> overflow_o=1 sticky, count stays DEPTH; repeat with wb_grant=1 same cycle -> push accepted, no overflow.
REQ-035 ALU_NOP and rd=0 ADD inputs -> no wr_en, no wake_valid, count unchanged.
REQ-036 3 entries queued, assert reset 1 cycle -> wr_en=0, ready_o=1, overflow_o=0, no further writes of old tags.

Source files
------------

// File: rtl/alu_wb_p0.sv
// Port-0 ALU with an in-order result queue feeding a shared register-file write port.
// Each retired result is broadcast as a wakeup in the same cycle it is written.
package alu_wb_p0_pkg;
   typedef enum logic [3:0] {
      ALU_NOP  = 4'd0,
      ALU_ADD  = 4'd1,
      ALU_SUB  = 4'd2,
      ALU_SLL  = 4'd3,
      ALU_SR   = 4'd4,
      ALU_SRA  = 4'd5,
      ALU_SLT  = 4'd6,
      ALU_SLTU = 4'd7,
      ALU_XOR  = 4'd8,
      ALU_OR   = 4'd9,
      ALU_AND  = 4'd10
   } alu_func_e;

   typedef struct packed {
      logic [31:0] lhs;
      logic [31:0] rhs;
      logic [6:0]  rd;
      alu_func_e   alu_func;
   } INSTRUCTION_ALU;
endpackage

module alu_wb_p0
   import alu_wb_p0_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  INSTRUCTION_ALU instruction_i,
   output logic           ready_o,
   output logic           wr_en,
   output logic [6:0]     wr_addr,
   output logic [31:0]    wr_data,
   input  logic           wb_grant,
   output logic           wake_valid,
   output logic [6:0]     wake_tag,
   output logic           overflow_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
   localparam logic [CW-1:0] READY_MAX  = CW'(DEPTH - 4);

   logic [38:0]   mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          overflow_q;

   logic [31:0]   result;
   logic          op_valid;
   logic [4:0]    shamt;
   logic          push_req, push, pop, full;

   assign shamt = instruction_i.rhs[4:0];

   always_comb begin
      result   = '0;
      op_valid = 1'b1;
      case (instruction_i.alu_func)
         ALU_ADD:  result = instruction_i.lhs + instruction_i.rhs;
         ALU_SUB:  result = instruction_i.lhs - instruction_i.rhs;
         ALU_SLL:  result = instruction_i.lhs << shamt;
         ALU_SR:   result = instruction_i.lhs >> shamt;
         ALU_SRA:  result = $unsigned($signed(instruction_i.lhs) >>> shamt);
         ALU_SLT:  result = {31'd0, $signed(instruction_i.lhs) < $signed(instruction_i.rhs)};
         ALU_SLTU: result = {31'd0, instruction_i.lhs < instruction_i.rhs};
         ALU_XOR:  result = instruction_i.lhs ^ instruction_i.rhs;
         ALU_OR:   result = instruction_i.lhs | instruction_i.rhs;
         ALU_AND:  result = instruction_i.lhs & instruction_i.rhs;
         default:  op_valid = 1'b0;
      endcase
   end

   assign wr_en    = (count != '0);
   assign full     = (count == FULL_COUNT);
   assign pop      = wr_en & wb_grant;
   assign push_req = op_valid && (instruction_i.rd != '0);
   // A pop in the same cycle frees the head slot, so a full queue can still accept.
   assign push     = push_req && (!full || pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push_req && full && !pop) overflow_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && push) mem[wr_ptr] <= {instruction_i.rd, result};
   end

   assign {wr_addr, wr_data} = mem[rd_ptr];
   assign wake_valid = pop;
   assign wake_tag   = wr_addr;
   assign ready_o    = (count <= READY_MAX);
   assign overflow_o = overflow_q;

endmodule
